// File: rtl/req_enc_pkg.sv
// Shared definitions for the sequential 16->4 request encoder.
//
// Contents:
//   WIDTH, IDX_W       request bitmap width and index width
//   req_enc_state_t    encoder FSM states (IDLE, DRAIN)
//   req_vec_t          request bitmap type
//   req_idx_t          index type
//   clear_bit()        returns a bitmap with one indexed bit cleared
package req_enc_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } req_enc_state_t;

  typedef logic [WIDTH-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  // Clear the bit selected by idx; all other bits pass through.
  function automatic req_vec_t clear_bit(input req_vec_t vec, input req_idx_t idx);
    req_vec_t mask;
    mask = req_vec_t'(1) << idx;
    return vec & ~mask;
  endfunction

endpackage

// File: rtl/prio_encoder16_4.sv
// Combinational priority encoder with a movable search start.
//
// Finds the first set bit of vec at or above start, wrapping modulo WIDTH.
// With start tied to zero this is a plain lowest-index-first encoder.
//
// Ports:
//   vec                  in   WIDTH  bitmap to search
//   start                in   IDX_W  index where the search begins
//   idx                  out  IDX_W  selected index (0 when vec is empty)
//   found                out  1      vec has at least one set bit
//   onehot_count_is_one  out  1      exactly one bit of vec is set
module prio_encoder16_4
  import req_enc_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             onehot_count_is_one
);

  logic [2*WIDTH-1:0] doubled;
  req_vec_t           rotated;
  req_idx_t           offset;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no
    // latch is inferred when the loop finds nothing.
    offset = '0;

    // Rotating the bitmap right by start turns the wrapped search into a plain
    // lowest-set-bit search; the offset is then added back modulo WIDTH.
    doubled = {vec, vec} >> start;
    rotated = doubled[WIDTH-1:0];

    // Scan high to low so the last hit, i.e. the lowest set bit, wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end

    found = |vec;
    // The index wraps naturally in IDX_W bits because WIDTH is a power of two.
    idx   = found ? (start + offset) : '0;

    // Clearing the lowest set bit leaves zero only for a single-bit bitmap.
    onehot_count_is_one = found && ((vec & (vec - req_vec_t'(1))) == '0);
  end

endmodule

// File: rtl/req_encoder16_4.sv
// Sequential 16->4 request encoder.
//
// Accepts a 16-bit request bitmap and emits the index of every set bit, one
// per valid/ready handshake, clearing each bit as it is consumed. out_idx and
// out_last are combinational from the registered pending bitmap, so the first
// index appears the cycle after the bitmap is accepted.
//
// Build option:
//   REQ_ENC_ROUND_ROBIN_EN  defined: search starts at rr_ptr, which moves to
//                           one past each transferred index and survives
//                           across bitmaps. Undefined: lowest index first.
//
// Ports:
//   clk         in   1      clock, all state on posedge
//   reset       in   1      synchronous, active-high
//   load_valid  in   1      load_vec is valid
//   load_ready  out  1      a new bitmap can be accepted (IDLE only)
//   load_vec    in   WIDTH  request bitmap, bit i requests index i
//   out_valid   out  1      out_idx holds a pending index
//   out_ready   in   1      consumer takes out_idx this cycle
//   out_idx     out  IDX_W  index of the selected pending bit (0 when idle)
//   out_last    out  1      out_idx is the final pending bit
//   pending     out  WIDTH  bits not yet emitted (registered)
module req_encoder16_4
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [WIDTH-1:0] pending
);

  req_enc_state_t state_q, state_d;
  req_vec_t       pending_q, pending_d;

  req_idx_t       search_start;
  req_idx_t       enc_idx;
  logic           enc_found;
  logic           enc_single;
  logic           transfer;

  prio_encoder16_4 u_prio (
    .vec                 (pending_q),
    .start               (search_start),
    .idx                 (enc_idx),
    .found               (enc_found),
    .onehot_count_is_one (enc_single)
  );

  assign transfer = out_valid & out_ready;
  assign pending  = pending_q;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  req_idx_t rr_ptr_q;

  assign search_start = rr_ptr_q;

  // Pointer moves one past each consumed index; IDX_W-bit arithmetic wraps
  // 15 to 0. Only reset clears it, so fairness carries across bitmaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (transfer) begin
      rr_ptr_q <= out_idx + req_idx_t'(1);
    end
  end
`else
  assign search_start = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_idx    = '0;
    out_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        // An empty bitmap is accepted but leaves nothing to drain.
        if (load_valid && (load_vec != '0)) begin
          pending_d = load_vec;
          state_d   = DRAIN;
        end
      end

      DRAIN: begin
        // load_valid is deliberately ignored here; the bitmap is not latched.
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = enc_single;
        if (out_ready) begin
          pending_d = clear_bit(pending_q, enc_idx);
          if (enc_single) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // enc_found is implied by DRAIN; kept visible for debug only.
  logic unused_found;
  assign unused_found = enc_found;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
